// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for a simple accumulator machine.
// Fetches an instruction over a handshake memory port, decodes a 4-bit
// opcode and drives the datapath register load/select lines.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   opcode[3:0]     opcode field from the instruction register
//   mem_ack         memory completion strobe
//   reg_clr_n       active-low clear to datapath registers (low only in CLR)
//   pc_ld, ir_ld, mar_ld, mdr_ld, acc_ld   register load controls
//   pc_sel          PC source: 0 = PC+1, 1 = jump target
//   acc_sel         ACC source: 0 = ALU result, 1 = MDR
//   mem_req, mem_we memory request / write enable
//   instr_done      one-cycle pulse when an instruction retires
//   halted, err     sticky status flags, cleared only by rst
//
// Opcodes: 0x1 LOAD, 0x2 STORE, 0x3 ALU, 0x4 JUMP, 0xF HALT, others NOP.
// A memory state that sees TIMEOUT consecutive cycles without mem_ack
// goes to ERR; an ack on the TIMEOUT-th cycle still completes normally.
module ctrl_seq #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       mem_ack,
    output logic       reg_clr_n,
    output logic       pc_ld,
    output logic       ir_ld,
    output logic       mar_ld,
    output logic       mdr_ld,
    output logic       acc_ld,
    output logic       pc_sel,
    output logic       acc_sel,
    output logic       mem_req,
    output logic       mem_we,
    output logic       instr_done,
    output logic       halted,
    output logic       err
);

    localparam logic [3:0] S_CLR     = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_IMEM    = 4'd2;
    localparam logic [3:0] S_DECODE  = 4'd3;
    localparam logic [3:0] S_DMEM_RD = 4'd4;
    localparam logic [3:0] S_DMEM_WR = 4'd5;
    localparam logic [3:0] S_WB      = 4'd6;
    localparam logic [3:0] S_EXEC    = 4'd7;
    localparam logic [3:0] S_JMP     = 4'd8;
    localparam logic [3:0] S_HALT    = 4'd9;
    localparam logic [3:0] S_ERR     = 4'd10;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ALU   = 4'h3;
    localparam logic [3:0] OP_JUMP  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Value of the wait counter on the TIMEOUT-th cycle of a memory state.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       in_mem;
    logic       timed_out;

    assign in_mem    = (state_q == S_IMEM) || (state_q == S_DMEM_RD) ||
                       (state_q == S_DMEM_WR);
    assign timed_out = in_mem && !mem_ack && (wait_q == WAIT_LAST);

    always_comb begin
        state_d    = state_q;
        reg_clr_n  = 1'b1;
        pc_ld      = 1'b0;
        ir_ld      = 1'b0;
        mar_ld     = 1'b0;
        mdr_ld     = 1'b0;
        acc_ld     = 1'b0;
        pc_sel     = 1'b0;
        acc_sel    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_CLR: begin
                reg_clr_n = 1'b0;
                state_d   = S_FETCH;
            end
            S_FETCH: begin
                mar_ld  = 1'b1;
                state_d = S_IMEM;
            end
            S_IMEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_ld   = 1'b1;
                    pc_ld   = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD: begin
                        mar_ld  = 1'b1;
                        state_d = S_DMEM_RD;
                    end
                    OP_STORE: begin
                        mar_ld  = 1'b1;
                        state_d = S_DMEM_WR;
                    end
                    OP_ALU:  state_d = S_EXEC;
                    OP_JUMP: state_d = S_JMP;
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        // NOP and unknown opcodes retire right here.
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_DMEM_RD: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    mdr_ld  = 1'b1;
                    state_d = S_WB;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_DMEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                acc_ld     = 1'b1;
                acc_sel    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC: begin
                acc_ld     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JMP: begin
                pc_ld      = 1'b1;
                pc_sel     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            S_ERR:  err    = 1'b1;
            default: state_d = S_CLR;
        endcase
    end

    // Only a memory state that waits on itself keeps counting; any state
    // change clears the counter so every memory state is entered at 0.
    assign wait_d = (in_mem && state_d == state_q) ? wait_q + 8'd1 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLR;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed-vector bench for ctrl_seq (TIMEOUT=4). Each vector drives
// rst/opcode/mem_ack after the falling edge and compares the packed
// output word against a hand-computed value for the expected state.
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       mem_ack = 1'b0;
    logic reg_clr_n, pc_ld, ir_ld, mar_ld, mdr_ld, acc_ld;
    logic pc_sel, acc_sel, mem_req, mem_we, instr_done, halted, err;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    always #5 clk = ~clk;

    ctrl_seq #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ack(mem_ack),
        .reg_clr_n(reg_clr_n), .pc_ld(pc_ld), .ir_ld(ir_ld),
        .mar_ld(mar_ld), .mdr_ld(mdr_ld), .acc_ld(acc_ld),
        .pc_sel(pc_sel), .acc_sel(acc_sel), .mem_req(mem_req),
        .mem_we(mem_we), .instr_done(instr_done), .halted(halted),
        .err(err)
    );

    // Bit order: reg_clr_n pc_ld ir_ld mar_ld mdr_ld acc_ld pc_sel acc_sel
    //            mem_req mem_we instr_done halted err
    logic [12:0] outs;
    assign outs = {reg_clr_n, pc_ld, ir_ld, mar_ld, mdr_ld, acc_ld, pc_sel,
                   acc_sel, mem_req, mem_we, instr_done, halted, err};

    localparam logic [12:0] X_CLR    = 13'h0000;
    localparam logic [12:0] X_FETCH  = 13'h1200;
    localparam logic [12:0] X_IWAIT  = 13'h1010;
    localparam logic [12:0] X_IACK   = 13'h1C10;
    localparam logic [12:0] X_DNOP   = 13'h1004;
    localparam logic [12:0] X_DMEM   = 13'h1200;
    localparam logic [12:0] X_DOTHER = 13'h1000;
    localparam logic [12:0] X_RWAIT  = 13'h1010;
    localparam logic [12:0] X_RACK   = 13'h1110;
    localparam logic [12:0] X_WB     = 13'h10A4;
    localparam logic [12:0] X_WWAIT  = 13'h1018;
    localparam logic [12:0] X_WACK   = 13'h101C;
    localparam logic [12:0] X_EXEC   = 13'h1084;
    localparam logic [12:0] X_JMP    = 13'h1844;
    localparam logic [12:0] X_HALT   = 13'h1002;
    localparam logic [12:0] X_ERR    = 13'h1001;

    task automatic check(input string tag, input logic [12:0] got,
                         input logic [12:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, let outputs settle, compare.
    task automatic cyc(input logic r, input logic [3:0] op, input logic ack,
                       input logic [12:0] exp, input string tag);
        @(negedge clk);
        rst = r; opcode = op; mem_ack = ack;
        #1;
        check(tag, outs, exp);
    endtask

    // FETCH then IMEM with immediate ack, presenting op for the DECODE cycle.
    task automatic fetch(input logic [3:0] op);
        cyc(1'b0, op, 1'b1, X_FETCH, "fetch");   // ack outside memory ignored
        cyc(1'b0, op, 1'b1, X_IACK, "imem_ack");
    endtask

    initial begin
        // Reset and the single extra CLR cycle after rst falls.
        cyc(1'b1, 4'h0, 1'b1, X_CLR, "rst_clr");
        cyc(1'b0, 4'h0, 1'b1, X_CLR, "clr_after_rst");

        // NOP loop, ack tied high: 3-cycle instruction.
        for (int unsigned i = 0; i < 3; i++) begin
            fetch(4'h0);
            cyc(1'b0, 4'h0, 1'b1, X_DNOP, "nop_decode");
        end

        // LOAD, ack delayed 3 cycles (ack on the 4th = TIMEOUT-th cycle).
        fetch(4'h1);
        cyc(1'b0, 4'h1, 1'b0, X_DMEM, "ld_decode");
        cyc(1'b0, 4'h0, 1'b0, X_RWAIT, "ld_wait1");
        cyc(1'b0, 4'h0, 1'b0, X_RWAIT, "ld_wait2");
        cyc(1'b0, 4'h0, 1'b0, X_RWAIT, "ld_wait3");
        cyc(1'b0, 4'h0, 1'b1, X_RACK, "ld_ack");
        cyc(1'b0, 4'h0, 1'b0, X_WB, "ld_wb");

        // STORE, immediate ack.
        fetch(4'h2);
        cyc(1'b0, 4'h2, 1'b1, X_DMEM, "st_decode");
        cyc(1'b0, 4'h0, 1'b1, X_WACK, "st_ack");

        // ALU, JUMP, unknown opcode.
        fetch(4'h3);
        cyc(1'b0, 4'h3, 1'b0, X_DOTHER, "alu_decode");
        cyc(1'b0, 4'h0, 1'b0, X_EXEC, "alu_exec");
        fetch(4'h4);
        cyc(1'b0, 4'h4, 1'b0, X_DOTHER, "jmp_decode");
        cyc(1'b0, 4'h0, 1'b0, X_JMP, "jmp_exec");
        fetch(4'h7);
        cyc(1'b0, 4'h7, 1'b0, X_DNOP, "unk_decode");

        // IMEM ack on the TIMEOUT-th cycle: completes normally.
        cyc(1'b0, 4'h0, 1'b0, X_FETCH, "to_fetch");
        for (int unsigned i = 0; i < 3; i++)
            cyc(1'b0, 4'h0, 1'b0, X_IWAIT, "to_iwait");
        cyc(1'b0, 4'h0, 1'b1, X_IACK, "to_ack4");
        cyc(1'b0, 4'h0, 1'b0, X_DNOP, "to_decode");

        // IMEM with no ack: ERR on the 5th cycle, sticky, cleared by rst.
        cyc(1'b0, 4'h0, 1'b0, X_FETCH, "err_fetch");
        for (int unsigned i = 0; i < 4; i++)
            cyc(1'b0, 4'h0, 1'b0, X_IWAIT, "err_iwait");
        cyc(1'b0, 4'h0, 1'b1, X_ERR, "err_set");
        cyc(1'b0, 4'h0, 1'b0, X_ERR, "err_sticky");
        cyc(1'b1, 4'h0, 1'b0, X_ERR, "err_rst_cycle");
        cyc(1'b0, 4'h0, 1'b0, X_CLR, "err_clr");

        // rst during the 2nd DMEM_WR wait cycle: no completion, back to CLR.
        fetch(4'h2);
        cyc(1'b0, 4'h2, 1'b0, X_DMEM, "wr_decode");
        cyc(1'b0, 4'h0, 1'b0, X_WWAIT, "wr_wait1");
        cyc(1'b1, 4'h0, 1'b0, X_WWAIT, "wr_wait2_rst");
        cyc(1'b0, 4'h0, 1'b1, X_CLR, "wr_clr");

        // HALT: sticky through 20 cycles of ack toggling, cleared by rst.
        fetch(4'hF);
        cyc(1'b0, 4'hF, 1'b0, X_DOTHER, "halt_decode");
        for (int unsigned i = 0; i < 20; i++)
            cyc(1'b0, 4'h0, 1'(i & 1), X_HALT, "halt_hold");
        cyc(1'b1, 4'h0, 1'b0, X_HALT, "halt_rst_cycle");
        cyc(1'b0, 4'h0, 1'b0, X_CLR, "halt_clr");

        // Counter starts at 0 after reset: 3 waits + ack on 4th, no ERR.
        cyc(1'b0, 4'h0, 1'b0, X_FETCH, "post_fetch");
        for (int unsigned i = 0; i < 3; i++)
            cyc(1'b0, 4'h0, 1'b0, X_IWAIT, "post_iwait");
        cyc(1'b0, 4'h1, 1'b1, X_IACK, "post_ack");
        cyc(1'b0, 4'h1, 1'b0, X_DMEM, "post_decode");
        for (int unsigned i = 0; i < 3; i++)
            cyc(1'b0, 4'h0, 1'b0, X_RWAIT, "post_rwait");
        cyc(1'b0, 4'h0, 1'b1, X_RACK, "post_rack");
        cyc(1'b0, 4'h0, 1'b0, X_WB, "post_wb");
        cyc(1'b0, 4'h0, 1'b0, X_FETCH, "post_fetch2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter: TIMEOUT, 16, max consecutive cycles a memory state waits for mem_ack before error (legal 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 opcode  input  4  opcode field from instruction-register output.
REQ-005 mem_ack  input  1  memory completion strobe, sampled on clk rising edge.
REQ-006 reg_clr_n  output  1  active-low synchronous clear to all datapath load/store registers.
REQ-007 pc_ld, ir_ld, mar_ld, mdr_ld, acc_ld  output  1 each  load controls (c lines) of the PC, IR, MAR, MDR and ACC registers.
REQ-008 pc_sel  output  1  PC source: 0 = PC+1, 1 = jump target.
REQ-009 acc_sel  output  1  ACC source: 0 = ALU result, 1 = MDR.
REQ-010 mem_req, mem_we  output  1 each  memory request; write when mem_we=1.
REQ-011 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-012 halted, err  output  1 each  sticky status flags.

Function
REQ-013 Block SHALL be a single FSM with states CLR, FETCH, IMEM, DECODE, DMEM_RD, DMEM_WR, WB, EXEC, JMP, HALT, ERR.
REQ-014 All outputs not listed as asserted in a state SHALL be 0; reg_clr_n SHALL be 1 except in CLR.
REQ-015 CLR: reg_clr_n=0; next FETCH.
REQ-016 FETCH: mar_ld=1; next IMEM.
REQ-017 IMEM: mem_req=1, mem_we=0; if mem_ack=1 then ir_ld=1, pc_ld=1, pc_sel=0 in that same cycle and next DECODE; else stay.
REQ-018 DECODE: mar_ld=1 when opcode is 0x1 or 0x2; next by opcode: 0x1 DMEM_RD, 0x2 DMEM_WR, 0x3 EXEC, 0x4 JMP, 0xF HALT, all others (incl. 0x0 NOP) FETCH.
REQ-019 DMEM_RD: mem_req=1, mem_we=0; on mem_ack mdr_ld=1 same cycle and next WB; else stay.
REQ-020 WB: acc_ld=1, acc_sel=1; next FETCH.
REQ-021 DMEM_WR: mem_req=1, mem_we=1; on mem_ack next FETCH; else stay.
REQ-022 EXEC: acc_ld=1, acc_sel=0; next FETCH.
REQ-023 JMP: pc_ld=1, pc_sel=1; next FETCH.
REQ-024 instr_done SHALL be 1 in the last state of each instruction: DECODE for NOP/unknown opcodes, WB, EXEC, JMP, and DMEM_WR when mem_ack=1.
REQ-025 HALT: halted=1; SHALL remain until rst.
REQ-026 ERR: err=1; SHALL remain until rst.
REQ-027 Memory states (IMEM, DMEM_RD, DMEM_WR) SHALL count consecutive cycles with mem_ack=0; the counter SHALL be 0 on entry to any memory state.
REQ-028 If the TIMEOUT-th cycle of a memory state has mem_ack=0, next state SHALL be ERR; mem_ack=1 on that cycle SHALL complete normally (ack wins).
REQ-029 mem_ack outside memory states SHALL be ignored.
REQ-030 A DECODE for a NOP/unknown opcode SHALL take exactly 1 cycle.
REQ-031 Instruction latencies, rst deassert to first FETCH excluded, with mem_ack returned on the first memory-state cycle: NOP 3, ALU/JUMP 4, STORE 4, LOAD 5 cycles.

Reset
REQ-032 rst=1 at a clk edge SHALL put the FSM in CLR and zero the wait counter, regardless of current state, including mid memory wait, HALT and ERR.
REQ-033 While rst=1 the FSM SHALL stay in CLR, so reg_clr_n=0 and all other outputs are 0 from the edge after rst is first sampled high.
REQ-034 After rst falls, CLR SHALL last exactly 1 more cycle, then FETCH.

Verification
REQ-035 Reset then mem_ack tied to 1 and opcode=0x0 -> state sequence CLR, FETCH, IMEM, DECODE repeats; instr_done pulses once every 3 cycles; ir_ld and pc_ld=1 in each IMEM cycle.
REQ-036 opcode=0x1 with mem_ack delayed 3 cycles in DMEM_RD -> mem_req high 4 cycles, mdr_ld=1 only on the ack cycle, then acc_ld=1 with acc_sel=1 for one cycle.
REQ-037 opcode=0x2, ack on the first DMEM_WR cycle -> mem_we=1 for exactly 1 cycle, instr_done=1 in that same cycle, next state FETCH.
REQ-038 TIMEOUT=4, mem_ack held 0 in IMEM -> err=1 from the 5th cycle after IMEM entry; repeat with ack on the 4th cycle -> no error, DECODE follows.
REQ-039 opcode=0xF -> halted=1 and stays 1 for 20 cycles of mem_ack toggling; rst pulse -> halted=0, reg_clr_n=0 one cycle after rst falls, then FETCH.
REQ-040 rst asserted during the 2nd cycle of a DMEM_WR wait -> mem_req and mem_we=0 from the next edge; no instr_done pulse.
